// File: rtl/av_gpio_pkg.sv
// Shared field layout, opcodes and helpers for the PS-to-PL GPIO motor command path.
package av_gpio_pkg;

    localparam int TOG_BIT = 31;
    localparam int OP_MSB  = 30;
    localparam int OP_LSB  = 28;
    localparam int PAY_W   = 16;

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_SET_L      = 3'd1;
    localparam logic [2:0] OP_SET_R      = 3'd2;
    localparam logic [2:0] OP_SET_BOTH   = 3'd3;
    localparam logic [2:0] OP_SET_PERIOD = 3'd4;
    localparam logic [2:0] OP_STOP       = 3'd5;

    localparam int ST_ACK = 31;
    localparam int ST_WDT = 30;
    localparam int ST_BAD = 29;

    // One extra bit so that -32768 yields +32768 instead of wrapping.
    function automatic logic [PAY_W:0] pay_magnitude(input logic [PAY_W-1:0] pay);
        return pay[PAY_W-1] ? ({1'b0, ~pay} + (PAY_W+1)'(1)) : {1'b0, pay};
    endfunction

endpackage

// File: rtl/gpio_cmd_pwm_driver_pwm_channel.sv
// One motor channel: shadow/active duty and direction, wrap-time load and PWM compare.
module pwm_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt,
    input  logic             wrap,
    input  logic             load,
    input  logic [CNT_W-1:0] load_duty,
    input  logic             load_dir,
    input  logic             clear,
    output logic             pwm,
    output logic             dir
);

    logic [CNT_W-1:0] shadow_duty;
    logic [CNT_W-1:0] active_duty;
    logic             shadow_dir;

    // NOTE: non-blocking assignments let wrap copy the old shadow while a new command overwrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_duty <= '0;
            active_duty <= '0;
            shadow_dir  <= 1'b0;
            dir         <= 1'b0;
            pwm         <= 1'b0;
        end else begin
            if (wrap) dir <= shadow_dir;
            if (clear) begin
                // Stop and watchdog beat both the wrap load and the compare.
                shadow_duty <= '0;
                active_duty <= '0;
                pwm         <= 1'b0;
            end else begin
                if (wrap) active_duty <= shadow_duty;
                if (load) begin
                    shadow_duty <= load_duty;
                    shadow_dir  <= load_dir;
                end
                pwm <= (cnt < active_duty);
            end
        end
    end

endmodule

// File: rtl/gpio_cmd_pwm_driver.sv
// Toggle-handshake motor command receiver on the PS EMIO GPIO word driving two PWM/direction channels.
module gpio_cmd_pwm_driver
    import av_gpio_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int DEFAULT_PERIOD = 2500,
    parameter int WDT_CYCLES     = 12500000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] gpio_cmd,
    output logic        gpio_ack,
    output logic [31:0] status,
    output logic        pwm_l,
    output logic        pwm_r,
    output logic        dir_l,
    output logic        dir_r,
    output logic        wdt_trip
);

    localparam int SS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int WDT_W = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = (WDT_CYCLES > 0) ? WDT_W'(WDT_CYCLES - 1) : '0;

    logic [SS-1:0]    tog_sync;
    logic             tog_seen;
    logic             cmd_valid;
    logic [2:0]       cmd_op;
    logic [PAY_W-1:0] cmd_pay;
    logic [CNT_W-1:0] cnt, period, period_new;
    logic             period_pend;
    logic [WDT_W-1:0] wdt_cnt;
    logic             bad_op;
    logic [PAY_W-1:0] last_payload;

    logic             cmd_pending, set_l, set_r, set_per, trip_now, clear, wrap;
    logic [PAY_W:0]   mag;
    logic [CNT_W-1:0] set_duty, per_clamped;
    logic             unused_cmd_bits;

    assign unused_cmd_bits = ^gpio_cmd[OP_LSB-1:PAY_W];
    assign cmd_pending     = tog_sync[SS-1] ^ tog_seen;

    // Only the toggle crosses the synchronizer; the PS holds the rest stable until acked.
    always_ff @(posedge clk) begin
        if (rst) begin
            tog_sync  <= '0;
            tog_seen  <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_pay   <= '0;
        end else begin
            tog_sync  <= {tog_sync[SS-2:0], gpio_cmd[TOG_BIT]};
            cmd_valid <= cmd_pending;
            if (cmd_pending) begin
                tog_seen <= tog_sync[SS-1];
                cmd_op   <= gpio_cmd[OP_MSB:OP_LSB];
                cmd_pay  <= gpio_cmd[PAY_W-1:0];
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        set_l       = cmd_valid && (cmd_op == OP_SET_L || cmd_op == OP_SET_BOTH);
        set_r       = cmd_valid && (cmd_op == OP_SET_R || cmd_op == OP_SET_BOTH);
        set_per     = cmd_valid && (cmd_op == OP_SET_PERIOD);
        trip_now    = (WDT_CYCLES != 0) && !cmd_valid && (wdt_cnt == WDT_LAST);
        clear       = trip_now || (cmd_valid && cmd_op == OP_STOP);
        mag         = pay_magnitude(cmd_pay);
        set_duty    = (32'(mag) > 32'(period)) ? period : CNT_W'(mag);
        per_clamped = (cmd_pay < PAY_W'(2)) ? CNT_W'(2) : CNT_W'(cmd_pay);
        wrap        = (cnt >= period - CNT_W'(1)) || (period_pend && cnt >= period_new);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            period      <= CNT_W'(DEFAULT_PERIOD);
            period_new  <= CNT_W'(DEFAULT_PERIOD);
            period_pend <= 1'b0;
        end else begin
            if (wrap) begin
                cnt <= '0;
                if (period_pend) begin
                    period      <= period_new;
                    period_pend <= 1'b0;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (set_per) begin
                period_new  <= per_clamped;
                period_pend <= 1'b1;
            end
        end
    end

    // An applied command always beats a watchdog trip in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_ack     <= 1'b0;
            wdt_cnt      <= '0;
            wdt_trip     <= 1'b0;
            bad_op       <= 1'b0;
            last_payload <= '0;
        end else begin
            gpio_ack <= tog_seen;
            if (cmd_valid) begin
                wdt_cnt      <= '0;
                wdt_trip     <= 1'b0;
                last_payload <= cmd_pay;
                bad_op       <= (cmd_op > OP_STOP);
            end else if (WDT_CYCLES != 0) begin
                if (wdt_cnt == WDT_LAST) wdt_trip <= 1'b1;
                else                     wdt_cnt  <= wdt_cnt + WDT_W'(1);
            end
        end
    end

    always_comb begin
        status               = '0;
        status[ST_ACK]       = gpio_ack;
        status[ST_WDT]       = wdt_trip;
        status[ST_BAD]       = bad_op;
        status[PAY_W-1:0]    = last_payload;
    end

    pwm_channel #(.CNT_W(CNT_W)) u_left (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .wrap      (wrap),
        .load      (set_l),
        .load_duty (set_duty),
        .load_dir  (cmd_pay[PAY_W-1]),
        .clear     (clear),
        .pwm       (pwm_l),
        .dir       (dir_l)
    );

    pwm_channel #(.CNT_W(CNT_W)) u_right (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .wrap      (wrap),
        .load      (set_r),
        .load_duty (set_duty),
        .load_dir  (cmd_pay[PAY_W-1]),
        .clear     (clear),
        .pwm       (pwm_r),
        .dir       (dir_r)
    );

endmodule
